link_vote_decoder: RTL and testbench
====================================

# link_vote_decoder

Parametrised decoder for the redundant key-state frames exchanged between the two game boards over the serial link. It takes the raw frame and strobe from the link receiver, votes the payload from three redundant copies plus a parity bit, and holds the last accepted value for the game controller. It adds a per-bit majority mode, error counting, and a link-loss timeout that releases all remote keys. It sits between `receiver` and the controller's remote-player key inputs, in the `LINK_CLK` domain.

## Interface
- `W`, 5: payload width, one bit per remote key.
- `MODE`, 0: 0 = pairwise word agreement; 1 = per-bit majority.
- `TIMEOUT`, 1000: `LINK_CLK` cycles without an accepted frame before the link is declared stale. Must be ≥1.
- `CLEAR_ON_STALE`, 1: 1 = `DATA` is forced to 0 while stale.
- `ERR_W`, 8: width of the reject counter.

Ports:
- `LINK_CLK`  in  1  clock.
- `RST`  in  1  reset. One clock; reset is synchronous and active-high.
- `RECV_OK`  in  1  one-cycle strobe: `RECV_DATA` holds a complete frame.
- `RECV_DATA`  in  3W+1  frame layout:
  - A = `[3W:2W+1]`
  - Bn = `[2W:W+1]`, the inverted copy; B = ~Bn
  - C = `[W:1]`
  - P = `[0]` = ~^payload
- `CLR_ERR`  in  1  synchronous clear of `ERR_CNT`.
- `DATA`  out  W  last accepted payload.
- `DATA_VALID`  out  1  pulse: frame accepted.
- `DATA_CHANGED`  out  1  pulse: accepted payload differs from the previous `DATA`.
- `CORRECTED`  out  1  pulse: accepted, but A, B and C were not all equal.
- `ERR_CNT`  out  ERR_W  saturating count of rejected frames.
- `LINK_STALE`  out  1  no accepted frame for `TIMEOUT` cycles.

## Operation
- **Decode.** Decode is combinational on `RECV_DATA`. Only cycles with `RECV_OK`=1 are evaluated. Define ok(x) = (~^x == P).
- **MODE 0.** First match wins:
  1. A==B && A==C → A
  2. A==B && ok(A) → A
  3. A==C && ok(A) → A
  4. B==C && ok(B) → B
  5. otherwise → reject
- **MODE 1.** M = bitwise maj(A,B,C). Accept M if A==B==C or ok(M); otherwise reject.
- **Accept.**
  - `DATA` ← payload; `DATA_VALID`=1.
  - `DATA_CHANGED` = (payload != old `DATA`).
  - `CORRECTED` = !(A==B==C).
  - Stale counter ← 0.
- **Reject.**
  - `ERR_CNT` += 1, saturating at 2^ERR_W−1.
  - `DATA` is unchanged; no pulses are raised.
- **Stale counter.**
  - Width $clog2(TIMEOUT+1).
  - Increments once per cycle without an accept; saturates at `TIMEOUT`.
  - `LINK_STALE` = (counter == `TIMEOUT`), registered.
- **Stale and `CLEAR_ON_STALE`=1.** `DATA` is driven 0 while stale. The held value is discarded, so the next accepted frame compares against 0 for `DATA_CHANGED`.
- **Simultaneous events.**
  - Accept in the cycle the counter would reach `TIMEOUT`: accept wins; counter = 0; `LINK_STALE` stays 0.
  - `CLR_ERR` together with a reject: clear wins; `ERR_CNT` = 0.
  - `RST` together with `RECV_OK`: reset wins; the frame is discarded.

## Timing
- **Latency.** One cycle. For `RECV_OK` sampled at edge t, the outputs change at edge t and are visible for cycle t+1.
- **Pulse width.** `DATA_VALID`, `DATA_CHANGED` and `CORRECTED` are exactly one cycle per accepted frame. Back-to-back strobes give back-to-back pulses.
- **Stale onset.** Accept at edge t → `LINK_STALE` rises at edge t+`TIMEOUT`. `DATA` clears at the same edge.
- **Reset values** (all outputs, from the first post-reset edge):
  - `DATA`=0, `DATA_VALID`=0, `DATA_CHANGED`=0, `CORRECTED`=0, `ERR_CNT`=0.
  - `LINK_STALE`=1; the counter resets to `TIMEOUT`, meaning no link yet.
- **Handshake.** There is no backpressure; every strobe is consumed.

## Structure
- **Package `link_pkg`:**
  - frame field offset functions for A/Bn/C/P given W;
  - the `link_parity` (~^) function;
  - MODE constants `LINK_MODE_PAIR` and `LINK_MODE_MAJ`.
  - The transmitter-side frame builder reuses the same package.
- **Sub-module `link_vote3`** (combinational, parameter W):
  - inputs: A, B, C, P, MODE;
  - outputs: payload, accept, all_equal.
- **Top.** `link_vote_decoder` holds only the registers, counters and pulse logic.

## Test plan
All scenarios use W=5, MODE=0, `CLEAR_ON_STALE`=1 unless stated.

1. **Clean frame.** `RECV_DATA`=10110_01001_10110_0 with `RECV_OK` for one cycle → next cycle `DATA`=10110, `DATA_VALID`=1, `DATA_CHANGED`=1, `CORRECTED`=0. The identical frame repeated gives `DATA_CHANGED`=0.
2. **Correction.**
   - MODE 0, frame 10110_01001_00000_0 → accept 10110 with `CORRECTED`=1.
   - MODE 1, frame 10110_01000_00110_0 → M=10110, accept, `CORRECTED`=1.
3. **Reject.** Frame 10110_11110_11111_1 (A, B, C all differ; no rule holds) → no `DATA_VALID`, `DATA` unchanged, `ERR_CNT` 0→1.
4. **Timeout** (`TIMEOUT`=8).
   - Accept 10110, then idle → `LINK_STALE`=1 and `DATA`=0 exactly 8 edges later.
   - A good frame → `LINK_STALE`=0 and `DATA` restored the next cycle.
   - An accept landing on the 8th edge keeps `LINK_STALE`=0.
5. **Counter saturation** (`ERR_W`=2). Five rejects → `ERR_CNT`=3. `CLR_ERR` in the same cycle as a reject → `ERR_CNT`=0.
6. **Reset mid-operation.** `RST`=1 in a cycle with `RECV_OK` carrying a valid frame → all outputs at their reset values, `LINK_STALE`=1, frame not accepted.

Source files
------------

// File: rtl/link_pkg.sv
// Shared frame layout and parity helpers for the board-to-board key-state link.
// Used by both the receive-side decoder and the transmit-side frame builder.
package link_pkg;

    localparam logic LINK_MODE_PAIR = 1'b0;
    localparam logic LINK_MODE_MAJ  = 1'b1;

    // Frame is {A, Bn, C, P}; Bn is the bitwise-inverted copy of the payload.
    function automatic int link_a_lsb(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int link_bn_lsb(input int w);
        return w + 1;
    endfunction

    function automatic int link_c_lsb(input int w);
        return (w > 0) ? 1 : 1;
    endfunction

    function automatic int link_p_bit(input int w);
        return (w > 0) ? 0 : 0;
    endfunction

    // Odd parity over the payload; zero-extension does not change the result.
    function automatic logic link_parity(input logic [31:0] x);
        return ~^x;
    endfunction

endpackage

// File: rtl/link_vote3.sv
// Combinational voter over the three redundant payload copies plus parity.
// Pair mode takes the first agreeing pair that also passes parity; majority mode votes per bit.
module link_vote3
    import link_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         p,
    input  logic         mode,
    output logic [W-1:0] payload,
    output logic         accept,
    output logic         all_equal
);

    logic [W-1:0] maj;
    logic         ok_a;
    logic         ok_b;
    logic         ok_m;

    assign maj       = (a & b) | (a & c) | (b & c);
    assign ok_a      = (link_parity(32'(a)) == p);
    assign ok_b      = (link_parity(32'(b)) == p);
    assign ok_m      = (link_parity(32'(maj)) == p);
    assign all_equal = (a == b) && (a == c);

    always_comb begin
        payload = '0;
        accept  = 1'b0;
        if (mode == LINK_MODE_MAJ) begin
            payload = maj;
            accept  = all_equal || ok_m;
        end else if (all_equal) begin
            payload = a;
            accept  = 1'b1;
        end else if ((a == b) && ok_a) begin
            payload = a;
            accept  = 1'b1;
        end else if ((a == c) && ok_a) begin
            payload = a;
            accept  = 1'b1;
        end else if ((b == c) && ok_b) begin
            payload = b;
            accept  = 1'b1;
        end
    end

endmodule

// File: rtl/link_vote_decoder.sv
// Holds the last voted key-state payload, raises per-frame pulses, counts rejects
// and declares the link stale after TIMEOUT cycles without an accepted frame.
module link_vote_decoder
    import link_pkg::*;
#(
    parameter int W              = 5,
    parameter int MODE           = 0,
    parameter int TIMEOUT        = 1000,
    parameter int CLEAR_ON_STALE = 1,
    parameter int ERR_W          = 8
) (
    input  logic             LINK_CLK,
    input  logic             RST,
    input  logic             RECV_OK,
    input  logic [3*W:0]     RECV_DATA,
    input  logic             CLR_ERR,
    output logic [W-1:0]     DATA,
    output logic             DATA_VALID,
    output logic             DATA_CHANGED,
    output logic             CORRECTED,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             LINK_STALE
);

    localparam int             SW       = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]  T_MAX    = SW'(TIMEOUT);
    localparam int             A_LSB    = link_a_lsb(W);
    localparam int             BN_LSB   = link_bn_lsb(W);
    localparam int             C_LSB    = link_c_lsb(W);
    localparam int             P_BIT    = link_p_bit(W);
    localparam logic           MODE_SEL = (MODE == 1) ? LINK_MODE_MAJ : LINK_MODE_PAIR;

    logic [W-1:0]  payload;
    logic          accept;
    logic          all_equal;
    logic          take;
    logic          drop;
    logic [SW-1:0] stale_cnt;
    logic [SW-1:0] stale_nxt;

    link_vote3 #(.W(W)) u_vote (
        .a         (RECV_DATA[A_LSB +: W]),
        .b         (~RECV_DATA[BN_LSB +: W]),
        .c         (RECV_DATA[C_LSB +: W]),
        .p         (RECV_DATA[P_BIT]),
        .mode      (MODE_SEL),
        .payload   (payload),
        .accept    (accept),
        .all_equal (all_equal)
    );

    assign take = RECV_OK && accept;
    assign drop = RECV_OK && !accept;

    // An accept always wins over the counter reaching TIMEOUT in the same cycle.
    always_comb begin
        stale_nxt = stale_cnt;
        if (take) begin
            stale_nxt = '0;
        end else if (stale_cnt != T_MAX) begin
            stale_nxt = stale_cnt + SW'(1);
        end
    end

    always_ff @(posedge LINK_CLK) begin
        if (RST) begin
            DATA         <= '0;
            DATA_VALID   <= 1'b0;
            DATA_CHANGED <= 1'b0;
            CORRECTED    <= 1'b0;
            ERR_CNT      <= '0;
            LINK_STALE   <= 1'b1;
            stale_cnt    <= T_MAX;
        end else begin
            DATA_VALID   <= take;
            DATA_CHANGED <= take && (payload != DATA);
            CORRECTED    <= take && !all_equal;
            stale_cnt    <= stale_nxt;
            LINK_STALE   <= (stale_nxt == T_MAX);

            // Clearing the held value means the next accept compares against zero.
            if (take) begin
                DATA <= payload;
            end else if ((CLEAR_ON_STALE != 0) && (stale_nxt == T_MAX)) begin
                DATA <= '0;
            end

            if (CLR_ERR) begin
                ERR_CNT <= '0;
            end else if (drop && (ERR_CNT != '1)) begin
                ERR_CNT <= ERR_CNT + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_link_vote_decoder.sv
// Directed bench: a pair-mode decoder (TIMEOUT=8, ERR_W=2) driven from a vector table,
// plus a majority-mode instance exercised by a short hand-written sequence.
module tb_link_vote_decoder;

    localparam logic [15:0] F_CLEAN  = 16'b10110_01001_10110_0;
    localparam logic [15:0] F_CLEAN2 = 16'b01100_10011_01100_1;
    localparam logic [15:0] F_CORR0  = 16'b10110_01001_00000_0;
    localparam logic [15:0] F_RULE4  = 16'b00000_10011_01100_1;
    localparam logic [15:0] F_BADP   = 16'b10110_01001_00000_1;
    localparam logic [15:0] F_MAJ    = 16'b10110_01000_00110_0;
    localparam logic [15:0] F_BAD    = 16'b10110_11110_11111_1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        recv_ok = 1'b0;
    logic [15:0] recv_data = '0;
    logic        clr_err = 1'b0;

    logic [4:0] data;
    logic       data_valid, data_changed, corrected, link_stale;
    logic [1:0] err_cnt;

    logic [4:0] m_data;
    logic       m_valid, m_changed, m_corrected, m_stale;
    logic [7:0] m_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    link_vote_decoder #(.W(5), .MODE(0), .TIMEOUT(8), .CLEAR_ON_STALE(1), .ERR_W(2)) dut (
        .LINK_CLK(clk), .RST(rst), .RECV_OK(recv_ok), .RECV_DATA(recv_data), .CLR_ERR(clr_err),
        .DATA(data), .DATA_VALID(data_valid), .DATA_CHANGED(data_changed),
        .CORRECTED(corrected), .ERR_CNT(err_cnt), .LINK_STALE(link_stale)
    );

    link_vote_decoder #(.W(5), .MODE(1), .TIMEOUT(8), .CLEAR_ON_STALE(1), .ERR_W(8)) dut_maj (
        .LINK_CLK(clk), .RST(rst), .RECV_OK(recv_ok), .RECV_DATA(recv_data), .CLR_ERR(clr_err),
        .DATA(m_data), .DATA_VALID(m_valid), .DATA_CHANGED(m_changed),
        .CORRECTED(m_corrected), .ERR_CNT(m_err), .LINK_STALE(m_stale)
    );

    typedef struct {
        logic        rst;
        logic        ok;
        logic        clr;
        logic [15:0] frame;
        logic [4:0]  e_data;
        logic        e_v;
        logic        e_ch;
        logic        e_co;
        logic [1:0]  e_err;
        logic        e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ok, input logic clr, input logic [15:0] f,
                       input logic [4:0] d, input logic v, input logic ch, input logic co,
                       input logic [1:0] e, input logic st);
        vec_t x;
        x.rst = r; x.ok = ok; x.clr = clr; x.frame = f;
        x.e_data = d; x.e_v = v; x.e_ch = ch; x.e_co = co; x.e_err = e; x.e_st = st;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ok, input logic clr, input logic [15:0] f);
        rst = r; recv_ok = ok; clr_err = clr; recv_data = f;
        @(posedge clk);
        #1;
        rst = 1'b0; recv_ok = 1'b0; clr_err = 1'b0; recv_data = '0;
    endtask

    initial begin
        add(1, 1, 0, F_CLEAN,  5'b00000, 0, 0, 0, 0, 1);
        add(0, 1, 0, F_CLEAN,  5'b10110, 1, 1, 0, 0, 0);
        add(0, 1, 0, F_CLEAN,  5'b10110, 1, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0,    5'b10110, 0, 0, 0, 0, 0);
        add(0, 1, 0, F_BAD,    5'b10110, 0, 0, 0, 1, 0);
        add(0, 1, 0, F_CLEAN2, 5'b01100, 1, 1, 0, 1, 0);
        add(0, 1, 0, F_CORR0,  5'b10110, 1, 1, 1, 1, 0);
        add(0, 1, 0, F_RULE4,  5'b01100, 1, 1, 1, 1, 0);
        add(0, 1, 0, F_BADP,   5'b01100, 0, 0, 0, 2, 0);
        add(0, 1, 0, F_MAJ,    5'b01100, 0, 0, 0, 3, 0);
        add(0, 1, 0, F_BAD,    5'b01100, 0, 0, 0, 3, 0);
        add(0, 1, 1, F_BAD,    5'b01100, 0, 0, 0, 0, 0);
        add(0, 1, 0, F_BAD,    5'b01100, 0, 0, 0, 1, 0);
        add(0, 1, 0, F_BAD,    5'b01100, 0, 0, 0, 2, 0);
        add(0, 0, 1, 16'h0,    5'b01100, 0, 0, 0, 0, 0);
        // Eighth edge after the last accept: accept wins, no stale.
        add(0, 1, 0, F_CLEAN,  5'b10110, 1, 1, 0, 0, 0);
        for (int i = 1; i < 8; i++) add(0, 0, 0, 16'h0, 5'b10110, 0, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0,    5'b00000, 0, 0, 0, 0, 1);
        add(0, 0, 0, 16'h0,    5'b00000, 0, 0, 0, 0, 1);
        add(0, 1, 0, F_CLEAN,  5'b10110, 1, 1, 0, 0, 0);
        add(0, 1, 0, F_BAD,    5'b10110, 0, 0, 0, 1, 0);
        add(1, 1, 0, F_CLEAN2, 5'b00000, 0, 0, 0, 0, 1);
        add(0, 0, 0, 16'h0,    5'b00000, 0, 0, 0, 0, 1);
        add(0, 1, 0, F_CLEAN,  5'b10110, 1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ok, vecs[i].clr, vecs[i].frame);
            chk($sformatf("v%0d data", i),    32'(data),         32'(vecs[i].e_data));
            chk($sformatf("v%0d valid", i),   32'(data_valid),   32'(vecs[i].e_v));
            chk($sformatf("v%0d changed", i), 32'(data_changed), 32'(vecs[i].e_ch));
            chk($sformatf("v%0d corr", i),    32'(corrected),    32'(vecs[i].e_co));
            chk($sformatf("v%0d err", i),     32'(err_cnt),      32'(vecs[i].e_err));
            chk($sformatf("v%0d stale", i),   32'(link_stale),   32'(vecs[i].e_st));
        end

        // Majority mode: frame rejected by pair mode is corrected by the bitwise vote.
        step(1, 0, 0, 16'h0);
        chk("maj rst stale", 32'(m_stale), 32'd1);
        chk("maj rst data", 32'(m_data), 32'd0);
        step(0, 1, 0, F_MAJ);
        chk("maj data", 32'(m_data), 32'b10110);
        chk("maj valid", 32'(m_valid), 32'd1);
        chk("maj changed", 32'(m_changed), 32'd1);
        chk("maj corr", 32'(m_corrected), 32'd1);
        chk("maj stale", 32'(m_stale), 32'd0);
        chk("pair on maj frame valid", 32'(data_valid), 32'd0);
        chk("pair on maj frame err", 32'(err_cnt), 32'd1);
        step(0, 1, 0, F_BADP);
        chk("maj badp valid", 32'(m_valid), 32'd0);
        chk("maj badp err", 32'(m_err), 32'd1);
        chk("maj badp data", 32'(m_data), 32'b10110);
        step(0, 1, 0, F_CLEAN2);
        chk("maj clean2 data", 32'(m_data), 32'b01100);
        chk("maj clean2 changed", 32'(m_changed), 32'd1);
        chk("maj clean2 corr", 32'(m_corrected), 32'd0);
        step(0, 1, 0, F_CLEAN2);
        chk("maj repeat changed", 32'(m_changed), 32'd0);
        chk("maj repeat valid", 32'(m_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
